// File: rtl/divisor_clock_multicanal.sv
// Runtime-programmable multi-channel clock divider: 50% duty outputs plus a one-cycle rise tick per channel.
// New half-periods take effect only when a half-period starts, so outputs never glitch.
module divisor_clock_multicanal #(
  parameter  int unsigned N_CH     = 2,
  parameter  int unsigned CNT_W    = 14,
  parameter  int unsigned DEF_HALF = 15624,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              Clck_in,
  input  logic              reset_Clock,
  input  logic [N_CH-1:0]   enable,
  input  logic              sync_restart,
  input  logic              load_en,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_val,
  output logic [N_CH-1:0]   Clock_out,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   pend
);

  logic [CNT_W-1:0] cnt_q      [N_CH];
  logic [CNT_W-1:0] cnt_d      [N_CH];
  logic [CNT_W-1:0] half_q     [N_CH];
  logic [CNT_W-1:0] half_d     [N_CH];
  logic [CNT_W-1:0] pend_val_q [N_CH];
  logic [CNT_W-1:0] pend_val_d [N_CH];
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  clk_q, clk_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic [N_CH-1:0]  load_hit_c;
  logic [N_CH-1:0]  terminal_c;

  // Out-of-range load_ch values match no channel and are dropped.
  always_comb begin
    for (int c = 0; c < int'(N_CH); c++) begin
      load_hit_c[c] = load_en && (load_ch == CH_W'(c));
      terminal_c[c] = (cnt_q[c] == half_q[c]);
    end
  end

  always_comb begin
    for (int c = 0; c < int'(N_CH); c++) begin
      cnt_d[c]      = cnt_q[c];
      half_d[c]     = half_q[c];
      pend_val_d[c] = pend_val_q[c];
      pend_d[c]     = pend_q[c];
      clk_d[c]      = clk_q[c];
      tick_d[c]     = 1'b0;
      if (!enable[c]) begin
        cnt_d[c] = '0;
        clk_d[c] = 1'b0;
        if (load_hit_c[c]) begin
          half_d[c] = load_val;
          pend_d[c] = 1'b0;
        end
      end else if (sync_restart || terminal_c[c]) begin
        // A new half-period starts here: pending and same-cycle loads land in half_q.
        cnt_d[c]  = '0;
        clk_d[c]  = sync_restart ? 1'b0 : ~clk_q[c];
        tick_d[c] = !sync_restart && !clk_q[c];
        if (pend_q[c]) begin
          half_d[c] = pend_val_q[c];
          pend_d[c] = 1'b0;
        end
        if (load_hit_c[c]) begin
          half_d[c] = load_val;
          pend_d[c] = 1'b0;
        end
      end else begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
        if (load_hit_c[c]) begin
          pend_val_d[c] = load_val;
          pend_d[c]     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clck_in or negedge reset_Clock) begin
    if (!reset_Clock) begin
      for (int c = 0; c < int'(N_CH); c++) begin
        cnt_q[c]      <= '0;
        half_q[c]     <= CNT_W'(DEF_HALF);
        pend_val_q[c] <= '0;
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

  assign Clock_out = clk_q;
  assign tick      = tick_q;
  assign pend      = pend_q;

endmodule

// File: tb/tb_divisor_clock_multicanal.sv
// Bench for divisor_clock_multicanal: per-cycle scoreboard against a behavioural model plus directed timing checks.
// A second 3-channel instance exercises an out-of-range load_ch.
module tb_divisor_clock_multicanal;

  localparam int unsigned N_CH     = 2;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned DEF_HALF = 4;

  logic             clk_in = 1'b0;
  logic             reset_n = 1'b1;
  logic [1:0]       enable = '0;
  logic             sync_restart = 1'b0;
  logic             load_en = 1'b0;
  logic [0:0]       load_ch = '0;
  logic [CNT_W-1:0] load_val = '0;
  logic [1:0]       clock_out, tick, pend;

  logic [2:0]       enable3 = '0;
  logic             sync3 = 1'b0;
  logic             load3_en = 1'b0;
  logic [1:0]       load_ch3 = '0;
  logic [CNT_W-1:0] load_val3 = '0;
  logic [2:0]       clock_out3, tick3, pend3;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int         m_cnt [2];
  int         m_half[2];
  int         m_pv  [2];
  logic [1:0] m_pend, m_clk, m_tick;
  logic [5:0] sb_q[$];

  always #5 clk_in = ~clk_in;

  divisor_clock_multicanal #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
    .Clck_in(clk_in), .reset_Clock(reset_n), .enable(enable), .sync_restart(sync_restart),
    .load_en(load_en), .load_ch(load_ch), .load_val(load_val),
    .Clock_out(clock_out), .tick(tick), .pend(pend)
  );

  divisor_clock_multicanal #(.N_CH(3), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut3 (
    .Clck_in(clk_in), .reset_Clock(reset_n), .enable(enable3), .sync_restart(sync3),
    .load_en(load3_en), .load_ch(load_ch3), .load_val(load_val3),
    .Clock_out(clock_out3), .tick(tick3), .pend(pend3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_cnt[c]  = 0;
      m_half[c] = int'(DEF_HALF);
      m_pv[c]   = 0;
    end
    m_pend = '0;
    m_clk  = '0;
    m_tick = '0;
  endtask

  // Next-state prediction from the inputs presented before the coming edge.
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      bit hit;
      hit = load_en && (int'(load_ch) == c);
      m_tick[c] = 1'b0;
      if (!enable[c]) begin
        m_cnt[c] = 0;
        m_clk[c] = 1'b0;
        if (hit) begin m_half[c] = int'(load_val); m_pend[c] = 1'b0; end
      end else if (sync_restart) begin
        m_cnt[c] = 0;
        m_clk[c] = 1'b0;
        if (m_pend[c]) begin m_half[c] = m_pv[c]; m_pend[c] = 1'b0; end
        if (hit) begin m_half[c] = int'(load_val); m_pend[c] = 1'b0; end
      end else if (m_cnt[c] == m_half[c]) begin
        m_cnt[c]  = 0;
        m_tick[c] = !m_clk[c];
        m_clk[c]  = !m_clk[c];
        if (m_pend[c]) begin m_half[c] = m_pv[c]; m_pend[c] = 1'b0; end
        if (hit) begin m_half[c] = int'(load_val); m_pend[c] = 1'b0; end
      end else begin
        m_cnt[c]++;
        if (hit) begin m_pv[c] = int'(load_val); m_pend[c] = 1'b1; end
      end
    end
  endtask

  // One clock: predict, push, advance, pop and compare, then drop the strobes.
  task automatic step();
    logic [5:0] exp_v;
    model_step();
    sb_q.push_back({m_clk, m_tick, m_pend});
    @(posedge clk_in);
    #1;
    cyc++;
    exp_v = sb_q.pop_front();
    chk($sformatf("cycle%0d_outputs", cyc), 32'({clock_out, tick, pend}), 32'(exp_v));
    sync_restart = 1'b0;
    load_en      = 1'b0;
    load3_en     = 1'b0;
  endtask

  task automatic steps_to_edge(input int ch, input bit rising, input int max_n, output int n);
    logic prev;
    n = 0;
    forever begin
      prev = clock_out[ch];
      step();
      n++;
      if (clock_out[ch] == rising && prev != rising) break;
      if (n >= max_n) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, tg, tk, f0, f1, co, fc;
    logic prev;
    model_reset();

    // Reset and start-up timing
    #2 reset_n = 1'b0;
    #20;
    chk("reset_clock_out", 32'(clock_out), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_pend", 32'(pend), 32'd0);
    enable  = 2'b11;
    enable3 = 3'b111;
    @(negedge clk_in);
    reset_n   = 1'b1;
    load3_en  = 1'b1;
    load_ch3  = 2'd3;
    load_val3 = 8'd0;
    steps_to_edge(0, 1'b1, 20, n);
    chk("t1_first_rise", 32'(n), 32'd5);
    chk("t1_tick", 32'(tick[0]), 32'd1);
    chk("t1_dut3_clk", 32'(clock_out3), 32'd7);
    chk("t1_dut3_tick", 32'(tick3), 32'd7);
    chk("t1_dut3_pend", 32'(pend3), 32'd0);
    steps_to_edge(0, 1'b0, 20, n);
    chk("t1_high_len", 32'(n), 32'd5);
    steps_to_edge(0, 1'b1, 20, n);
    chk("t1_low_len", 32'(n), 32'd5);
    chk("t1_dut3_clk_2nd", 32'(clock_out3), 32'd7);

    // Load 9 to ch0 mid half-period
    step();
    step();
    load_en = 1'b1; load_ch = 1'b0; load_val = 8'd9;
    step();
    chk("t2_pend_set", 32'(pend[0]), 32'd1);
    steps_to_edge(0, 1'b0, 20, n);
    chk("t2_current_half", 32'(n), 32'd2);
    chk("t2_pend_clear", 32'(pend[0]), 32'd0);
    steps_to_edge(0, 1'b1, 30, n);
    chk("t2_new_low_len", 32'(n), 32'd10);
    steps_to_edge(0, 1'b0, 30, n);
    chk("t2_new_high_len", 32'(n), 32'd10);

    // H=0 on ch1
    load_en = 1'b1; load_ch = 1'b1; load_val = 8'd0;
    step();
    for (int i = 0; i < 12 && pend[1]; i++) step();
    chk("t3_pend_clear", 32'(pend[1]), 32'd0);
    tg = 0; tk = 0;
    for (int i = 0; i < 8; i++) begin
      prev = clock_out[1];
      step();
      if (clock_out[1] != prev) tg++;
      if (tick[1]) tk++;
    end
    chk("t3_toggles", 32'(tg), 32'd8);
    chk("t3_ticks", 32'(tk), 32'd4);

    // Disable ch0 during its high phase, reload while disabled, re-enable
    steps_to_edge(0, 1'b1, 30, n);
    step();
    step();
    chk("t4_high_before", 32'(clock_out[0]), 32'd1);
    enable = 2'b10;
    step();
    chk("t4_clk_dropped", 32'(clock_out[0]), 32'd0);
    chk("t4_no_tick", 32'(tick[0]), 32'd0);
    load_en = 1'b1; load_ch = 1'b0; load_val = 8'd4;
    step();
    chk("t4_disabled_load_no_pend", 32'(pend[0]), 32'd0);
    step();
    enable = 2'b11;
    steps_to_edge(0, 1'b1, 20, n);
    chk("t4_reenable_rise", 32'(n), 32'd5);

    // sync_restart with ch1 loaded to H=2 in the same cycle
    sync_restart = 1'b1;
    load_en = 1'b1; load_ch = 1'b1; load_val = 8'd2;
    step();
    chk("t5_both_low", 32'(clock_out), 32'd0);
    chk("t5_sync_no_pend", 32'(pend), 32'd0);
    f0 = 0; f1 = 0; co = 0; fc = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (tick[0] && f0 == 0) f0 = k;
      if (tick[1] && f1 == 0) f1 = k;
      if (tick[0] && tick[1]) begin
        co++;
        if (fc == 0) fc = k;
      end
    end
    chk("t5_ch0_first_rise", 32'(f0), 32'd5);
    chk("t5_ch1_first_rise", 32'(f1), 32'd3);
    chk("t5_first_coincide", 32'(fc), 32'd15);
    chk("t5_coincide_count", 32'(co), 32'd2);

    // Pending load, then asynchronous reset between edges
    if (m_cnt[0] == m_half[0]) step();
    load_en = 1'b1; load_ch = 1'b0; load_val = 8'd7;
    step();
    chk("t6_pend_before_reset", 32'(pend[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_clock_out", 32'(clock_out), 32'd0);
    chk("t6_async_tick", 32'(tick), 32'd0);
    chk("t6_async_pend", 32'(pend), 32'd0);
    chk("t6_async_dut3_clk", 32'(clock_out3), 32'd0);
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    reset_n = 1'b1;
    steps_to_edge(0, 1'b1, 30, n);
    chk("t6_rise_after_reset", 32'(n), 32'd5);
    chk("t6_ch1_rise_after_reset", 32'(clock_out[1]), 32'd1);
    steps_to_edge(0, 1'b1, 30, n);
    chk("t6_period_after_reset", 32'(n), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
